// File: rtl/copr_burst_loader_if.sv
// copr_burst_loader_if
// Groups every non-clock/reset signal of the burst loader into one bundle.
//   control  : start, abort, size (in)  / busy, done (out)
//   counter  : cnt_count, cnt_endcount (in) / cnt_clear, cnt_max, cnt_go (out)
//   memory   : mem_rdata (in) / mem_en, mem_addr (out)
//   dataflow : full (in) / dout, dout_wr (out)
// Modport master is the loader side, slave is the surrounding environment.
interface copr_burst_loader_if #(
  parameter int SIZECOUNT = 5,
  parameter int DATA_W    = 32
);
  logic                 start;
  logic                 abort;
  logic [SIZECOUNT-1:0] size;
  logic                 busy;
  logic                 done;
  logic                 cnt_clear;
  logic [SIZECOUNT-1:0] cnt_max;
  logic                 cnt_go;
  logic [SIZECOUNT-1:0] cnt_count;
  logic                 cnt_endcount;
  logic                 mem_en;
  logic [SIZECOUNT-1:0] mem_addr;
  logic [DATA_W-1:0]    mem_rdata;
  logic                 full;
  logic [DATA_W-1:0]    dout;
  logic                 dout_wr;

  modport master (
    input  start, abort, size, cnt_count, cnt_endcount, mem_rdata, full,
    output busy, done, cnt_clear, cnt_max, cnt_go, mem_en, mem_addr, dout, dout_wr
  );

  modport slave (
    output start, abort, size, cnt_count, cnt_endcount, mem_rdata, full,
    input  busy, done, cnt_clear, cnt_max, cnt_go, mem_en, mem_addr, dout, dout_wr
  );
endinterface

// File: rtl/copr_burst_loader.sv
// copr_burst_loader
// Drives an external up-counter to stream `size` words out of a coprocessor
// local memory (1-cycle read latency) into a dataflow port with full/wr flow
// control. A single skid register catches the word that is already in flight
// when full rises, so nothing is dropped or duplicated.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : copr_burst_loader_if.master (control, counter, memory, dataflow)
//   dbg_state  : current FSM state (0 IDLE, 1 CLR, 2 RUN, 3 DONE)
// Flow control: a word is transferred downstream in any cycle where dout_wr=1;
// dout_wr is never asserted while full=1, and full is honoured combinationally.
module copr_burst_loader #(
  parameter int SIZECOUNT = 5,
  parameter int DATA_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  copr_burst_loader_if.master bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [SIZECOUNT-1:0] cnt_max_q, cnt_max_d;
  logic                 pending_q, pending_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]    skid_data_q, skid_data_d;

  logic                 busy_c;
  logic                 done_c;
  logic                 cnt_clear_c;
  logic                 cnt_go_c;
  logic                 dout_wr_c;
  logic [DATA_W-1:0]    dout_c;
  logic                 abort_active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_max_q    <= '0;
      pending_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_max_q    <= cnt_max_d;
      pending_q    <= pending_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_max_d    = cnt_max_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    busy_c       = (state_q != S_IDLE);
    done_c       = 1'b0;
    cnt_clear_c  = 1'b0;
    cnt_go_c     = 1'b0;
    dout_wr_c    = 1'b0;
    dout_c       = '0;
    abort_active = bus.abort && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          cnt_max_d = bus.size;
          state_d   = S_CLR;
        end
      end
      S_CLR: begin
        cnt_clear_c = 1'b1;
        state_d     = S_RUN;
      end
      S_RUN: begin
        // A new read is only issued when the skid is empty and downstream can
        // take data, so at most one word is ever buffered.
        cnt_go_c = !bus.cnt_endcount && !bus.full && !skid_valid_q;
        if (skid_valid_q && !bus.full) begin
          dout_wr_c    = 1'b1;
          dout_c       = skid_data_q;
          skid_valid_d = 1'b0;
        end else if (pending_q && !bus.full) begin
          dout_wr_c = 1'b1;
          dout_c    = bus.mem_rdata;
        end else if (pending_q && bus.full) begin
          skid_data_d  = bus.mem_rdata;
          skid_valid_d = 1'b1;
        end
        if (bus.cnt_endcount && !pending_q && !skid_valid_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pending_d = cnt_go_c;

    // Abort overrides everything: clear the counter, drop any in-flight or
    // buffered word and return to IDLE without signalling done.
    if (abort_active) begin
      state_d      = S_IDLE;
      cnt_clear_c  = 1'b1;
      cnt_go_c     = 1'b0;
      pending_d    = 1'b0;
      skid_valid_d = 1'b0;
      dout_wr_c    = 1'b0;
      dout_c       = '0;
      done_c       = 1'b0;
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.cnt_clear = cnt_clear_c;
  assign bus.cnt_max   = cnt_max_q;
  assign bus.cnt_go    = cnt_go_c;
  assign bus.mem_en    = cnt_go_c;
  assign bus.mem_addr  = bus.cnt_count;
  assign bus.dout      = dout_c;
  assign bus.dout_wr   = dout_wr_c;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_copr_burst_loader.sv
// tb_copr_burst_loader
// Directed bench for copr_burst_loader. Provides behavioural models of the
// external up-counter and the 1-cycle-latency memory, drives one cycle at a
// time, logs per-cycle activity as bitmasks / queues, and compares against
// hand-derived expectations.
module tb_copr_burst_loader;

  localparam int SC = 5;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic [1:0]    dbg_state;

  copr_burst_loader_if #(.SIZECOUNT(SC), .DATA_W(DW)) bus ();

  copr_burst_loader #(.SIZECOUNT(SC), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  logic [SC-1:0] count;
  logic [DW-1:0] rdata;
  logic [DW-1:0] mem [0:31];

  always @(posedge clk or posedge reset) begin
    if (reset)                                  count <= '0;
    else if (bus.cnt_clear)                     count <= '0;
    else if (bus.cnt_go && count != bus.cnt_max) count <= count + 1'b1;
  end
  assign bus.cnt_count    = count;
  assign bus.cnt_endcount = (count == bus.cnt_max);

  always @(posedge clk or posedge reset) begin
    if (reset)           rdata <= '0;
    else if (bus.mem_en) rdata <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata;

  // ---------------- logging / scoreboard ----------------
  int             checks;
  int             failures;
  int             cyc;
  logic [63:0]    m_en, m_wr, m_done, m_busy, m_clr;
  logic [SC-1:0]  cmax_log [0:63];
  logic [DW-1:0]  got_q[$];
  logic [DW-1:0]  exp_q[$];
  logic [SC-1:0]  addr_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < 32; i++) mem[i] = base + DW'(i);
  endtask

  task automatic clear_log();
    cyc = 0; m_en = '0; m_wr = '0; m_done = '0; m_busy = '0; m_clr = '0;
    got_q.delete(); exp_q.delete(); addr_q.delete();
    for (int i = 0; i < 64; i++) cmax_log[i] = '0;
  endtask

  // Drive inputs for one cycle, sample 1 time unit later, advance to #1 past
  // the next rising edge.
  task automatic run_cycle(input logic s, input logic a, input logic [SC-1:0] sz, input logic f);
    bus.start = s; bus.abort = a; bus.size = sz; bus.full = f;
    #1;
    if (cyc < 64) begin
      if (bus.mem_en)    begin m_en = m_en | (64'd1 << cyc); addr_q.push_back(bus.mem_addr); end
      if (bus.dout_wr)   begin m_wr = m_wr | (64'd1 << cyc); got_q.push_back(bus.dout); end
      if (bus.done)      m_done = m_done | (64'd1 << cyc);
      if (bus.busy)      m_busy = m_busy | (64'd1 << cyc);
      if (bus.cnt_clear) m_clr  = m_clr  | (64'd1 << cyc);
      cmax_log[cyc] = bus.cnt_max;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic expect_words(input string tag, input logic [DW-1:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + DW'(i));
    check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic expect_addrs(input string tag, input int n);
    check({tag, "_alen"}, 64'(addr_q.size()), 64'(n));
    for (int i = 0; i < n && i < addr_q.size(); i++)
      check($sformatf("%s_a%0d", tag, i), 64'(addr_q[i]), 64'(i));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
    check({tag, "_outs"},
          64'({bus.busy, bus.done, bus.cnt_clear, bus.cnt_go, bus.mem_en, bus.dout_wr}), 64'd0);
    check({tag, "_cmax"}, 64'(bus.cnt_max), 64'd0);
    check({tag, "_dout"}, 64'(bus.dout), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0; failures = 0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.size = '0; bus.full = 1'b0;
    fill(32'h0);
    clear_log();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // T1: size=4, no back-pressure
    fill(32'hA0); clear_log();
    run_cycle(1, 0, 5'd4, 0);
    repeat (11) run_cycle(0, 0, 5'd4, 0);
    check("t1_mem_en", m_en,   64'h3C);
    check("t1_wr",     m_wr,   64'h78);
    check("t1_done",   m_done, 64'h100);
    check("t1_busy",   m_busy, 64'h1FE);
    check("t1_clr",    m_clr,  64'h2);
    expect_addrs("t1", 4);
    expect_words("t1", 32'hA0, 4);

    // T2: size=0 goes straight to DONE
    clear_log();
    run_cycle(1, 0, 5'd0, 0);
    repeat (7) run_cycle(0, 0, 5'd0, 0);
    check("t2_mem_en", m_en,   64'h0);
    check("t2_wr",     m_wr,   64'h0);
    check("t2_done",   m_done, 64'h8);
    check("t2_busy",   m_busy, 64'hE);

    // T3: size=6, full only in cycle 5 when the 3rd word arrives
    fill(32'hD0); clear_log();
    run_cycle(1, 0, 5'd6, 0);
    for (int c = 1; c < 16; c++) run_cycle(0, 0, 5'd6, (c == 5));
    check("t3_mem_en", m_en,   64'h39C);
    check("t3_wr",     m_wr,   64'h758);
    check("t3_done",   m_done, 64'h1000);
    expect_addrs("t3", 6);
    expect_words("t3", 32'hD0, 6);

    // T4: size=5, full held for cycles 1..10
    fill(32'h1000); clear_log();
    run_cycle(1, 0, 5'd5, 0);
    for (int c = 1; c < 22; c++) run_cycle(0, 0, 5'd5, (c >= 1 && c <= 10));
    check("t4_mem_en", m_en,   64'hF800);
    check("t4_wr",     m_wr,   64'h1F000);
    check("t4_done",   m_done, 64'h40000);
    expect_words("t4", 32'h1000, 5);

    // T5: size=8, abort in cycle 6 (4th word arriving)
    fill(32'h2000); clear_log();
    run_cycle(1, 0, 5'd8, 0);
    for (int c = 1; c < 10; c++) run_cycle(0, (c == 6), 5'd8, 0);
    check("t5_mem_en", m_en,   64'h3C);
    check("t5_wr",     m_wr,   64'h38);
    check("t5_done",   m_done, 64'h0);
    check("t5_busy",   m_busy, 64'h7E);
    check("t5_clr",    m_clr,  64'h42);
    expect_words("t5", 32'h2000, 3);

    // T5b: follow-up size=2 completes normally
    fill(32'h3000); clear_log();
    run_cycle(1, 0, 5'd2, 0);
    repeat (8) run_cycle(0, 0, 5'd2, 0);
    check("t5b_mem_en", m_en,   64'hC);
    check("t5b_wr",     m_wr,   64'h18);
    check("t5b_done",   m_done, 64'h40);
    check("t5b_busy",   m_busy, 64'h7E);
    expect_words("t5b", 32'h3000, 2);

    // T6: start held high with toggling size during a size=3 run
    fill(32'h4000); clear_log();
    run_cycle(1, 0, 5'd3, 0);
    for (int c = 1; c < 8; c++) run_cycle(1, 0, (c % 2 == 1) ? 5'd7 : 5'd1, 0);
    check("t6_mem_en", m_en,   64'h1C);
    check("t6_wr",     m_wr,   64'h38);
    check("t6_done",   m_done, 64'h80);
    check("t6_clr",    m_clr,  64'h2);
    check("t6_cmax3",  64'(cmax_log[3]), 64'd3);
    check("t6_cmax6",  64'(cmax_log[6]), 64'd3);
    expect_words("t6", 32'h4000, 3);
    // New transfer, then reset while in RUN
    run_cycle(1, 0, 5'd5, 0);
    repeat (3) run_cycle(0, 0, 5'd5, 0);
    check("t6_in_run", 64'(dbg_state), 64'd2);
    reset = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    clear_log();
    repeat (4) run_cycle(0, 0, 5'd5, 0);
    check("t6_post_busy", m_busy, 64'h0);
    check("t6_post_en",   m_en,   64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
